// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder: closed-loop monitor that decodes the phase pattern read back from a 4-phase stepper.
// Define HALF_STEP_EN to decode the 8-pattern half-step sequence; by default only the 4 full-step patterns are legal.
module stepper_phase_decoder #(
  parameter int POS_W         = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int STALL_CYCLES  = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [3:0]              fase,
  input  logic                    clr_pos,
  input  logic                    fault_clr,
  output logic signed [POS_W-1:0] position,
  output logic                    dir_o,
  output logic                    step_pulse,
  output logic                    locked,
  output logic                    stalled,
  output logic                    fault,
  output logic [1:0]              fault_code
);

`ifdef HALF_STEP_EN
  localparam int IDX_W = 3;
`else
  localparam int IDX_W = 2;
`endif
  localparam int CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0]   STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_SKIP    = 2'b10;

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  typedef struct packed {
    logic             legal;
    logic [IDX_W-1:0] idx;
  } phase_t;

  function automatic phase_t decode(input logic [3:0] pat);
    phase_t d;
    d.legal = 1'b1;
    d.idx   = '0;
    case (pat)
`ifdef HALF_STEP_EN
      4'b0001: d.idx = IDX_W'(0);
      4'b0011: d.idx = IDX_W'(1);
      4'b0010: d.idx = IDX_W'(2);
      4'b0110: d.idx = IDX_W'(3);
      4'b0100: d.idx = IDX_W'(4);
      4'b1100: d.idx = IDX_W'(5);
      4'b1000: d.idx = IDX_W'(6);
      4'b1001: d.idx = IDX_W'(7);
`else
      4'b0001: d.idx = IDX_W'(0);
      4'b0010: d.idx = IDX_W'(1);
      4'b0100: d.idx = IDX_W'(2);
      4'b1000: d.idx = IDX_W'(3);
`endif
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  logic [3:0]         sync1, sync2, cand, filt, filt_d;
  logic [CNT_W-1:0]   stable_cnt, stable_cnt_next;
  logic [STALL_W-1:0] stall_cnt;
  logic [IDX_W-1:0]   ref_idx, delta;
  state_t             state, state_next;
  phase_t             dec;
  logic               evt, ref_load, step_fwd, step_bwd, fault_evt;
  logic [1:0]         fault_evt_code;

  // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= fase;
      sync2 <= sync1;
    end
  end

  // Run length of the current candidate; a pattern is accepted once it has been seen STABLE_CYCLES times in a row.
  always_comb begin
    if (sync2 != cand)                stable_cnt_next = CNT_W'(1);
    else if (stable_cnt == STABLE_MAX) stable_cnt_next = stable_cnt;
    else                               stable_cnt_next = stable_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand       <= '0;
      stable_cnt <= '0;
      filt       <= '0;
      filt_d     <= '0;
    end else begin
      cand       <= sync2;
      stable_cnt <= stable_cnt_next;
      if (stable_cnt_next == STABLE_MAX) filt <= sync2;
      filt_d     <= filt;
    end
  end

  assign dec   = decode(filt);
  assign delta = dec.idx - ref_idx;
  assign evt   = enable && (filt != filt_d) && (filt != 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) state <= UNLOCKED;
    else     state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_next     = state;
    ref_load       = 1'b0;
    step_fwd       = 1'b0;
    step_bwd       = 1'b0;
    fault_evt      = 1'b0;
    fault_evt_code = CODE_NONE;
    if (!enable) begin
      state_next = UNLOCKED;
    end else if (evt) begin
      if (!dec.legal) begin
        fault_evt      = 1'b1;
        fault_evt_code = CODE_ILLEGAL;
        state_next     = UNLOCKED;
      end else begin
        ref_load = 1'b1;
        if (state == UNLOCKED) begin
          state_next = LOCKED;
        end else if (delta == IDX_ONE) begin
          step_fwd = 1'b1;
        end else if (delta == '1) begin
          step_bwd = 1'b1;
        end else if (delta != '0) begin
          fault_evt      = 1'b1;
          fault_evt_code = CODE_SKIP;
          state_next     = UNLOCKED;
        end
      end
    end
    if (fault_clr) state_next = UNLOCKED;
  end

  always_comb begin
    locked  = (state == LOCKED);
    stalled = (stall_cnt == STALL_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      position   <= '0;
      dir_o      <= 1'b0;
      step_pulse <= 1'b0;
      fault      <= 1'b0;
      fault_code <= CODE_NONE;
      ref_idx    <= '0;
      stall_cnt  <= '0;
    end else begin
      step_pulse <= step_fwd | step_bwd;
      if (ref_load) ref_idx <= dec.idx;

      // A coincident clr_pos wins over the count, yet the step is still reported.
      if (clr_pos)       position <= '0;
      else if (step_fwd) position <= position + POS_W'(1);
      else if (step_bwd) position <= position - POS_W'(1);

      if (step_fwd)      dir_o <= 1'b1;
      else if (step_bwd) dir_o <= 1'b0;

      if (fault_clr) begin
        fault      <= fault_evt;
        fault_code <= fault_evt_code;
      end else if (fault_evt && !fault) begin
        fault      <= 1'b1;
        fault_code <= fault_evt_code;
      end

      if (state_next == UNLOCKED || step_fwd || step_bwd) stall_cnt <= '0;
      else if (state == LOCKED && stall_cnt != STALL_MAX)   stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder: directed scenarios plus random phase traffic, all checked cycle by cycle
// against a behavioural model built from pattern run lengths and modular index arithmetic.
module tb_stepper_phase_decoder;

  localparam int POS_W  = 16;
  localparam int STABLE = 4;
  localparam int STALL  = 20;
`ifdef HALF_STEP_EN
  localparam int NPAT = 8;
`else
  localparam int NPAT = 4;
`endif

  logic              clk = 1'b0;
  logic              rst, enable, clr_pos, fault_clr;
  logic [3:0]        fase;
  logic signed [POS_W-1:0] position;
  logic              dir_o, step_pulse, locked, stalled, fault;
  logic [1:0]        fault_code;
  logic [POS_W-1:0]  pos_u;

  assign pos_u = position;

  stepper_phase_decoder #(
    .POS_W(POS_W), .STABLE_CYCLES(STABLE), .STALL_CYCLES(STALL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fase(fase),
    .clr_pos(clr_pos), .fault_clr(fault_clr),
    .position(position), .dir_o(dir_o), .step_pulse(step_pulse),
    .locked(locked), .stalled(stalled), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] pat_of(input int i);
`ifdef HALF_STEP_EN
    case (i)
      0: return 4'b0001; 1: return 4'b0011; 2: return 4'b0010; 3: return 4'b0110;
      4: return 4'b0100; 5: return 4'b1100; 6: return 4'b1000; default: return 4'b1001;
    endcase
`else
    case (i)
      0: return 4'b0001; 1: return 4'b0010; 2: return 4'b0100; default: return 4'b1000;
    endcase
`endif
  endfunction

  function automatic int pat_idx(input logic [3:0] p);
    for (int i = 0; i < NPAT; i++) if (pat_of(i) == p) return i;
    return -1;
  endfunction

  // Reference model state
  logic [3:0]       m_dly0, m_dly1, run_val, m_filt, m_seen;
  int               run_len, m_ref, m_code, m_stall;
  logic [POS_W-1:0] m_pos;
  bit               m_locked, m_dir, m_step, m_fault;

  task automatic model_edge();
    bit lk_old, stepped, fev;
    int fcode, idx, d;
    logic [3:0] v;
    if (rst) begin
      m_dly0 = 0; m_dly1 = 0; run_val = 0; run_len = 0; m_filt = 0; m_seen = 0;
      m_ref = 0; m_code = 0; m_stall = 0; m_pos = 0;
      m_locked = 0; m_dir = 0; m_step = 0; m_fault = 0;
      return;
    end
    lk_old = m_locked; stepped = 0; fev = 0; fcode = 0;
    // A newly accepted filtered pattern is acted on one cycle after acceptance.
    if (enable && m_filt != m_seen && m_filt != 4'b0000) begin
      idx = pat_idx(m_filt);
      if (idx < 0) begin
        fev = 1; fcode = 1; m_locked = 0;
      end else if (!m_locked) begin
        m_locked = 1; m_ref = idx;
      end else begin
        d = (idx - m_ref + NPAT) % NPAT;
        if (d == 1) begin m_pos = m_pos + 1'b1; m_dir = 1; stepped = 1; end
        else if (d == NPAT - 1) begin m_pos = m_pos - 1'b1; m_dir = 0; stepped = 1; end
        else if (d != 0) begin fev = 1; fcode = 2; m_locked = 0; end
        m_ref = idx;
      end
    end
    m_seen = m_filt;
    if (!enable) m_locked = 0;
    if (fault_clr) begin
      m_locked = 0; m_fault = fev; m_code = fev ? fcode : 0;
    end else if (fev && !m_fault) begin
      m_fault = 1; m_code = fcode;
    end
    if (clr_pos) m_pos = 0;
    m_step = stepped;
    if (stepped || !m_locked) m_stall = 0;
    else if (lk_old && m_stall < STALL) m_stall++;
    // Filter: value seen STABLE times in a row on the 2-cycle-delayed stream is accepted.
    v = m_dly1; m_dly1 = m_dly0; m_dly0 = fase;
    if (v == run_val) run_len = (run_len < STABLE) ? run_len + 1 : STABLE;
    else begin run_val = v; run_len = 1; end
    if (run_len >= STABLE) m_filt = run_val;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    if (step_pulse) pulse_cnt++;
    check("position",   pos_u,      m_pos);
    check("dir_o",      dir_o,      m_dir);
    check("step_pulse", step_pulse, m_step);
    check("locked",     locked,     m_locked);
    check("stalled",    stalled,    m_stall == STALL);
    check("fault",      fault,      m_fault);
    check("fault_code", fault_code, m_code);
  endtask

  task automatic hold(input logic [3:0] p, input int n);
    fase = p;
    repeat (n) tick();
  endtask

  task automatic step_with_latency(input logic [3:0] p);
    int lat = -1;
    fase = p;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (step_pulse && lat < 0) lat = i;
    end
    check("latency", lat, STABLE + 3);
  endtask

  task automatic pulse_clr_pos();
    clr_pos = 1; tick(); clr_pos = 0;
  endtask

  task automatic pulse_fault_clr();
    fault_clr = 1; tick(); fault_clr = 0;
  endtask

  initial begin
    int p0, ci, r, n;
    rst = 1; enable = 0; fase = 0; clr_pos = 0; fault_clr = 0;
    repeat (2) tick();
    check("rst_position", pos_u, 0);
    check("rst_locked", locked, 0);
    rst = 0; enable = 1;

    // Forward walk: first pattern locks only, then four steps.
    hold(4'b0001, 10);
    check("lock_first", locked, 1);
    check("lock_no_count", pos_u, 0);
    p0 = pulse_cnt;
    step_with_latency(4'b0010);
    step_with_latency(4'b0100);
    step_with_latency(4'b1000);
    step_with_latency(4'b0001);
    check("fwd_pulses", pulse_cnt - p0, 4);
    check("fwd_position", pos_u, 4);
    check("fwd_dir", dir_o, 1);

    // Reverse from zero wraps below 0.
    pulse_clr_pos();
    hold(4'b1000, 10);
    hold(4'b0100, 10);
    check("rev_position", pos_u, 16'hFFFE);
    check("rev_dir", dir_o, 0);

    // Short glitch is filtered out.
    p0 = pulse_cnt;
    hold(4'b1000, 2);
    hold(4'b0100, 10);
    check("glitch_pulses", pulse_cnt - p0, 0);
    check("glitch_position", pos_u, 16'hFFFE);
    check("glitch_fault", fault, 0);

    // Skipped step, then clear and relock without counting.
    hold(4'b0001, 10);
    check("skip_fault", fault, 1);
    check("skip_code", fault_code, 2);
    check("skip_locked", locked, 0);
    pulse_fault_clr();
    hold(4'b0010, 10);
    check("clr_fault", fault, 0);
    check("relock", locked, 1);
    check("relock_position", pos_u, 16'hFFFE);

    // Illegal pattern; the first error code is kept.
    hold(4'b0101, 10);
    check("illegal_code", fault_code, 1);
    hold(4'b0011, 10);
    check("first_wins_code", fault_code, 1);
    check("first_wins_fault", fault, 1);
    pulse_fault_clr();

    // Stall, then a step coinciding with clr_pos.
    hold(4'b0001, 30);
    check("stall_set", stalled, 1);
    fase = 4'b0010;
    repeat (6) tick();
    clr_pos = 1;
    tick();
    clr_pos = 0;
    check("clr_step_pulse", step_pulse, 1);
    check("clr_step_position", pos_u, 0);
    check("stall_cleared", stalled, 0);
    repeat (5) tick();

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      n = $urandom_range(1, 14);
      ci = pat_idx(fase);
      if (ci < 0) ci = $urandom_range(0, NPAT - 1);
      if (r < 55) begin
        ci = ($urandom_range(0, 1) != 0) ? (ci + 1) % NPAT : (ci + NPAT - 1) % NPAT;
        hold(pat_of(ci), n);
      end else if (r < 62) hold(pat_of(ci), $urandom_range(22, 40));
      else if (r < 68) hold(4'b0000, n);
      else if (r < 73) hold(4'($urandom_range(0, 15)), n);
      else if (r < 79) hold(pat_of((ci + 2 + $urandom_range(0, NPAT - 4)) % NPAT), n);
      else if (r < 85) begin
        enable = 0;
        hold(pat_of((ci + 1) % NPAT), n);
        enable = 1;
      end else if (r < 91) pulse_clr_pos();
      else if (r < 97) pulse_fault_clr();
      else begin
        rst = 1; tick(); rst = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
